// File: rtl/rf_pkg.sv
// Shared definitions for the register-bank write-back path.
// Sizes, source identifiers and the write request bundle.
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int NREG   = 32;
    localparam int NSRC   = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LAM = 2'd1,
        SRC_JMP = 2'd2
    } src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle between the write producers (ALU, LAM, JMP) and the
// write-back arbiter, plus the register bank port C / port M outputs.
// Producer side: *_valid/*_rd/*_data in, *_ready out.
// Bank side: wc_rd/wc_data, wm_rd/wm_data, pend_mask, idle.
interface rf_wb_arbiter_if
    import rf_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;

    logic          lam_valid;
    logic          lam_ready;
    logic [AW-1:0] lam_rd;
    logic [DW-1:0] lam_data;

    logic          jmp_valid;
    logic          jmp_ready;
    logic [AW-1:0] jmp_rd;
    logic [DW-1:0] jmp_data;

    logic [AW-1:0] wc_rd;
    logic [DW-1:0] wc_data;
    logic [AW-1:0] wm_rd;
    logic [DW-1:0] wm_data;

    logic [(1<<AW)-1:0] pend_mask;
    logic               idle;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lam_valid, lam_rd, lam_data,
        input  jmp_valid, jmp_rd, jmp_data,
        output alu_ready, lam_ready, jmp_ready,
        output wc_rd, wc_data, wm_rd, wm_data,
        output pend_mask, idle
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lam_valid, lam_rd, lam_data,
        output jmp_valid, jmp_rd, jmp_data,
        input  alu_ready, lam_ready, jmp_ready,
        input  wc_rd, wc_data, wm_rd, wm_data,
        input  pend_mask, idle
    );

endinterface

// File: rtl/rf_wb_arbiter_slot.sv
// wb_slot: one-entry holding register for a single write producer.
// Ports: clk, reset, load, clr, rd_in/data_in -> v, rd, data.
module wb_slot #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clr,
    input  logic [AW-1:0] rd_in,
    input  logic [DW-1:0] data_in,
    output logic          v,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] data
);

    // A load wins over a clear: a granted slot may refill the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= 1'b0;
        end else if (load) begin
            v    <= 1'b1;
            rd   <= rd_in;
            data <= data_in;
        end else if (clr) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register bank's two write ports (C, M).
// Ports: clk, reset, bus (slave side of rf_wb_arbiter_if).
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic               clk,
    input  logic               reset,
    rf_wb_arbiter_if.slave     bus
);

    logic [NSRC-1:0] in_v;
    logic [NSRC-1:0] in_rdy;
    logic [NSRC-1:0] ld;
    logic [AW-1:0]   in_rd   [NSRC];
    logic [DW-1:0]   in_data [NSRC];

    logic [NSRC-1:0] slot_v;
    logic [AW-1:0]   slot_rd   [NSRC];
    logic [DW-1:0]   slot_data [NSRC];

    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] drop;
    logic [NSRC-1:0] clr;

    // Upper triangle of the age matrix: oij=1 means slot i is older.
    logic o01, o02, o12;
    logic [NSRC-1:0][NSRC-1:0] old;
    logic [1:0]      rank [NSRC];
    logic [NSRC-1:0] blk;

    logic       p0_v, p1_v;
    logic [1:0] p0_i, p1_i;

    logic [AW-1:0] wc_rd_q, wm_rd_q;
    logic [DW-1:0] wc_data_q, wm_data_q;
    logic [(1<<AW)-1:0] pm;

    assign in_v[SRC_ALU]    = bus.alu_valid;
    assign in_v[SRC_LAM]    = bus.lam_valid;
    assign in_v[SRC_JMP]    = bus.jmp_valid;
    assign in_rd[SRC_ALU]   = bus.alu_rd;
    assign in_rd[SRC_LAM]   = bus.lam_rd;
    assign in_rd[SRC_JMP]   = bus.jmp_rd;
    assign in_data[SRC_ALU] = bus.alu_data;
    assign in_data[SRC_LAM] = bus.lam_data;
    assign in_data[SRC_JMP] = bus.jmp_data;

    assign bus.alu_ready = in_rdy[SRC_ALU];
    assign bus.lam_ready = in_rdy[SRC_LAM];
    assign bus.jmp_ready = in_rdy[SRC_JMP];

    // Ready depends only on registered state (and reset), never on valid.
    assign clr    = grant | drop;
    assign in_rdy = reset ? '0 : (~slot_v | clr);
    assign ld     = in_v & in_rdy;

    for (genvar s = 0; s < NSRC; s++) begin : g_slot
        wb_slot #(.AW(AW), .DW(DW)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load    (ld[s]),
            .clr     (clr[s]),
            .rd_in   (in_rd[s]),
            .data_in (in_data[s]),
            .v       (slot_v[s]),
            .rd      (slot_rd[s]),
            .data    (slot_data[s])
        );
    end

    always_comb begin
        old       = '0;
        old[0][1] = o01;
        old[1][0] = !o01;
        old[0][2] = o02;
        old[2][0] = !o02;
        old[1][2] = o12;
        old[2][1] = !o12;
    end

    // rank = number of valid slots older than this one (0 = oldest).
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            rank[i] = '0;
            blk[i]  = 1'b0;
            for (int j = 0; j < NSRC; j++) begin
                if (j != i && slot_v[j] && old[j][i]) begin
                    rank[i] = rank[i] + 2'd1;
                    if (slot_rd[j] == slot_rd[i])
                        blk[i] = 1'b1;
                end
            end
        end
    end

    // Oldest-first scan. An older same-rd slot blocks a younger one, which
    // also keeps the two ports on distinct registers. rd=0 slots just drop.
    always_comb begin
        grant = '0;
        drop  = '0;
        p0_v  = 1'b0;
        p1_v  = 1'b0;
        p0_i  = '0;
        p1_i  = '0;
        for (int p = 0; p < NSRC; p++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (slot_v[i] && rank[i] == 2'(p)) begin
                    if (slot_rd[i] == '0) begin
                        drop[i] = 1'b1;
                    end else if (!blk[i] && !p1_v) begin
                        grant[i] = 1'b1;
                        if (!p0_v) begin
                            p0_v = 1'b1;
                            p0_i = 2'(i);
                        end else begin
                            p1_v = 1'b1;
                            p1_i = 2'(i);
                        end
                    end
                end
            end
        end
    end

    // Age update per pair: a loading slot is younger than any slot that
    // stays; among simultaneous loads the lower source index is older.
    function automatic logic age_nx(logic cur, logic li, logic lj);
        return li ? lj : (lj ? 1'b1 : cur);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            o01 <= 1'b0;
            o02 <= 1'b0;
            o12 <= 1'b0;
        end else begin
            o01 <= age_nx(o01, ld[0], ld[1]);
            o02 <= age_nx(o02, ld[0], ld[2]);
            o12 <= age_nx(o12, ld[1], ld[2]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wc_rd_q   <= '0;
            wc_data_q <= '0;
            wm_rd_q   <= '0;
            wm_data_q <= '0;
        end else begin
            wc_rd_q <= p0_v ? slot_rd[p0_i] : '0;
            wm_rd_q <= p1_v ? slot_rd[p1_i] : '0;
            if (p0_v)
                wc_data_q <= slot_data[p0_i];
            if (p1_v)
                wm_data_q <= slot_data[p1_i];
        end
    end

    always_comb begin
        pm = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (slot_v[i])
                pm[slot_rd[i]] = 1'b1;
        end
        pm[wc_rd_q] = 1'b1;
        pm[wm_rd_q] = 1'b1;
        pm[0]       = 1'b0;
    end

    assign bus.wc_rd     = wc_rd_q;
    assign bus.wc_data   = wc_data_q;
    assign bus.wm_rd     = wm_rd_q;
    assign bus.wm_data   = wm_data_q;
    assign bus.pend_mask = pm;
    assign bus.idle      = (slot_v == '0) && (wc_rd_q == '0)
                           && (wm_rd_q == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (wc_rd_q == '0 || wc_rd_q != wm_rd_q);
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed steps, then random traffic
// checked against an ordered write scoreboard.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wb_req_t q [$];
    int n_exp = 0;
    int n_seen = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int s, logic v, logic [4:0] rd, logic [31:0] d);
        case (s)
            0: begin bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d; end
            1: begin bus.lam_valid = v; bus.lam_rd = rd; bus.lam_data = d; end
            default: begin
                bus.jmp_valid = v; bus.jmp_rd = rd; bus.jmp_data = d;
            end
        endcase
    endtask

    function automatic logic rdy(int s);
        case (s)
            0: return bus.alu_ready;
            1: return bus.lam_ready;
            default: return bus.jmp_ready;
        endcase
    endfunction

    function automatic logic [2:0] rdy3();
        return {bus.jmp_ready, bus.lam_ready, bus.alu_ready};
    endfunction

    task automatic port_chk(string nm, logic [4:0] rd, logic [31:0] d);
        int found;
        if (rd != 5'd0) begin
            n_seen++;
            found = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].rd == rd) begin
                    found = i;
                    break;
                end
            end
            chk({nm, "_hit"}, 64'(found >= 0), 64'd1);
            if (found >= 0) begin
                chk({nm, "_data"}, 64'(d), 64'(q[found].data));
                q.delete(found);
            end
        end
    endtask

    logic        hv   [3];
    logic [4:0]  hrd  [3];
    logic [31:0] hdat [3];

    initial begin
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 32'd0);

        // reset for two edges
        tick();
        chk("rst_ready1", 64'(rdy3()), 64'd0);
        tick();
        chk("rst_ready2", 64'(rdy3()), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_wc_rd", 64'(bus.wc_rd), 64'd0);
        chk("rst_wm_rd", 64'(bus.wm_rd), 64'd0);
        chk("rst_pend", 64'(bus.pend_mask), 64'd0);
        chk("rst_idle", 64'(bus.idle), 64'd1);
        chk("rst_ready", 64'(rdy3()), 64'h7);

        // single write
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(0, 1'b0, 5'd0, 32'd0);
        chk("s_pend_n", 64'(bus.pend_mask), 64'h20);
        chk("s_wc_n", 64'(bus.wc_rd), 64'd0);
        tick();
        chk("s_wc_rd", 64'(bus.wc_rd), 64'd5);
        chk("s_wc_data", 64'(bus.wc_data), 64'hDEADBEEF);
        chk("s_wm_rd", 64'(bus.wm_rd), 64'd0);
        chk("s_pend_n1", 64'(bus.pend_mask), 64'h20);
        tick();
        chk("s_pend_n2", 64'(bus.pend_mask), 64'd0);
        chk("s_idle_n2", 64'(bus.idle), 64'd1);

        // dual write plus a waiting third
        drive(0, 1'b1, 5'd3, 32'hA0A0_0003);
        drive(1, 1'b1, 5'd7, 32'hB0B0_0007);
        drive(2, 1'b1, 5'd9, 32'hC0C0_0009);
        tick();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 32'd0);
        chk("d_pend", 64'(bus.pend_mask), 64'h288);
        tick();
        chk("d_wc_rd", 64'(bus.wc_rd), 64'd3);
        chk("d_wc_data", 64'(bus.wc_data), 64'hA0A0_0003);
        chk("d_wm_rd", 64'(bus.wm_rd), 64'd7);
        chk("d_wm_data", 64'(bus.wm_data), 64'hB0B0_0007);
        tick();
        chk("d_wc_rd2", 64'(bus.wc_rd), 64'd9);
        chk("d_wc_data2", 64'(bus.wc_data), 64'hC0C0_0009);
        chk("d_wm_rd2", 64'(bus.wm_rd), 64'd0);
        tick();
        chk("d_idle", 64'(bus.idle), 64'd1);

        // same-register conflict: LAM then ALU to r4
        drive(1, 1'b1, 5'd4, 32'd1);
        tick();
        drive(1, 1'b0, 5'd0, 32'd0);
        drive(0, 1'b1, 5'd4, 32'd2);
        chk("c_alu_rdy", 64'(bus.alu_ready), 64'd1);
        tick();
        drive(0, 1'b0, 5'd0, 32'd0);
        chk("c_wc_rd1", 64'(bus.wc_rd), 64'd4);
        chk("c_wc_data1", 64'(bus.wc_data), 64'd1);
        chk("c_wm_rd1", 64'(bus.wm_rd), 64'd0);
        tick();
        chk("c_wc_rd2", 64'(bus.wc_rd), 64'd4);
        chk("c_wc_data2", 64'(bus.wc_data), 64'd2);
        chk("c_wm_rd2", 64'(bus.wm_rd), 64'd0);
        tick();
        chk("c_idle", 64'(bus.idle), 64'd1);

        // reset while all three slots are full
        drive(0, 1'b1, 5'd10, 32'h10);
        drive(1, 1'b1, 5'd11, 32'h11);
        drive(2, 1'b1, 5'd12, 32'h12);
        tick();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 32'd0);
        chk("m_pend_full", 64'(bus.pend_mask), 64'h1C00);
        reset = 1'b1;
        #1;
        chk("m_rdy_rst", 64'(rdy3()), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("m_pend", 64'(bus.pend_mask), 64'd0);
        chk("m_idle", 64'(bus.idle), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("m_wc_rd", 64'(bus.wc_rd), 64'd0);
            chk("m_wm_rd", 64'(bus.wm_rd), 64'd0);
        end

        // random traffic against the scoreboard
        for (int s = 0; s < 3; s++) hv[s] = 1'b0;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            if (cyc >= 2000 && !hv[0] && !hv[1] && !hv[2] && q.size() == 0)
                break;
            for (int s = 0; s < 3; s++) begin
                if (!hv[s] && cyc < 2000 && $urandom_range(0, 9) < 7) begin
                    hv[s]   = 1'b1;
                    hrd[s]  = 5'($urandom_range(1, 31));
                    if (s == 2 && $urandom_range(0, 7) == 0) hrd[s] = 5'd0;
                    hdat[s] = $urandom;
                end
                drive(s, hv[s], hrd[s], hdat[s]);
            end
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                if (hv[s] && rdy(s)) begin
                    if (hrd[s] != 5'd0) begin
                        q.push_back('{rd: hrd[s], data: hdat[s]});
                        n_exp++;
                    end
                    hv[s] = 1'b0;
                end
            end
            tick();
            if (bus.wc_rd != 5'd0 && bus.wm_rd != 5'd0)
                chk("r_distinct", 64'(bus.wc_rd != bus.wm_rd), 64'd1);
            port_chk("r_wc", bus.wc_rd, bus.wc_data);
            port_chk("r_wm", bus.wm_rd, bus.wm_data);
        end
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 5'd0, 32'd0);
        chk("r_left", 64'(q.size()), 64'd0);
        chk("r_count", 64'(n_seen), 64'(n_exp));
        tick();
        chk("r_idle", 64'(bus.idle), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
